// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and helpers for the SRAM-like arbiter slice.
// Holds the transfer size encodings, the arbiter lock state and the ID-width helper.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Channel ID width; a single-bit ID is kept even for one channel.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of granted channel IDs, used to route responses back to their requester.
// Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
module sram_like_id_fifo #(
  parameter int DEPTH = 4,
  parameter int IDW   = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [IDW-1:0]           push_id,
  input  logic                     pop,
  output logic [IDW-1:0]           pop_id,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IDW-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_id  = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter merging N_CH SRAM-like channels onto one downstream port.
// Accepted channel IDs are queued so in-order responses return to their requester.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_CH-1:0]         ch_req,
  input  logic [N_CH-1:0]         ch_wr,
  input  logic [2*N_CH-1:0]       ch_size,
  input  logic [(DW/8)*N_CH-1:0]  ch_wstrb,
  input  logic [AW*N_CH-1:0]      ch_addr,
  input  logic [DW*N_CH-1:0]      ch_wdata,
  output logic [N_CH-1:0]         ch_addr_ok,
  output logic [N_CH-1:0]         ch_data_ok,
  output logic [DW-1:0]           ch_rdata,
  output logic                    m_req,
  output logic                    m_wr,
  output logic [1:0]              m_size,
  output logic [DW/8-1:0]         m_wstrb,
  output logic [AW-1:0]           m_addr,
  output logic [DW-1:0]           m_wdata,
  input  logic                    m_addr_ok,
  input  logic                    m_data_ok,
  input  logic [DW-1:0]           m_rdata,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    err_unexp
);

  localparam int IDW = id_width(N_CH);
  localparam int SW  = DW / 8;

  arb_state_e     state, state_n;
  logic [IDW-1:0] lock_id;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] rr_id;
  logic           rr_found;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] head_id;
  logic           full;
  logic           empty;
  logic           handshake;
  logic           pop;

  assign handshake = m_req && m_addr_ok;
  assign pop       = m_data_ok && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ARB_IDLE;
      lock_id    <= '0;
      last_grant <= IDW'(N_CH - 1);
      err_unexp  <= 1'b0;
    end else begin
      state <= state_n;
      if (m_req && !m_addr_ok) lock_id <= grant;
      if (handshake) last_grant <= grant;
      if (m_data_ok && empty) err_unexp <= 1'b1;
    end
  end

  // Two passes: channels above last_grant first, then wrap to the low ones.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!rr_found && ch_req[i] && (IDW'(i) > last_grant)) begin
        rr_found = 1'b1;
        rr_id    = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!rr_found && ch_req[i] && (IDW'(i) <= last_grant)) begin
        rr_found = 1'b1;
        rr_id    = IDW'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    if (m_req) state_n = m_addr_ok ? ARB_IDLE : ARB_LOCKED;
  end

  always_comb begin
    grant      = (state == ARB_LOCKED) ? lock_id : rr_id;
    m_req      = resetn && ((|ch_req) || (state == ARB_LOCKED)) && !full;
    m_wr       = 1'b0;
    m_size     = '0;
    m_wstrb    = '0;
    m_addr     = '0;
    m_wdata    = '0;
    ch_addr_ok = '0;
    ch_data_ok = '0;
    ch_rdata   = m_rdata;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (IDW'(i) == grant) begin
        m_wr          = ch_wr[i];
        m_size        = ch_size[2*i +: 2];
        m_wstrb       = ch_wstrb[i*SW +: SW];
        m_addr        = ch_addr[i*AW +: AW];
        m_wdata       = ch_wdata[i*DW +: DW];
        ch_addr_ok[i] = handshake;
      end
      if (IDW'(i) == head_id) ch_data_ok[i] = pop;
    end
  end

  sram_like_id_fifo #(
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (handshake),
    .push_id (grant),
    .pop     (pop),
    .pop_id  (head_id),
    .full    (full),
    .empty   (empty),
    .count   (outstanding)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based reference model.
module tb_sram_like_arbiter;

  localparam int N_CH  = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int IDW   = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [N_CH-1:0]   ch_req, ch_wr;
  logic [1:0]        a_size  [N_CH];
  logic [SW-1:0]     a_wstrb [N_CH];
  logic [AW-1:0]     a_addr  [N_CH];
  logic [DW-1:0]     a_wdata [N_CH];
  logic [2*N_CH-1:0] ch_size;
  logic [SW*N_CH-1:0] ch_wstrb;
  logic [AW*N_CH-1:0] ch_addr;
  logic [DW*N_CH-1:0] ch_wdata;
  logic [N_CH-1:0]   ch_addr_ok, ch_data_ok;
  logic [DW-1:0]     ch_rdata;
  logic              m_req, m_wr;
  logic [1:0]        m_size;
  logic [SW-1:0]     m_wstrb;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic              m_addr_ok, m_data_ok;
  logic [DW-1:0]     m_rdata;
  logic [CW-1:0]     outstanding;
  logic              err_unexp;

  assign ch_size  = {a_size[1], a_size[0]};
  assign ch_wstrb = {a_wstrb[1], a_wstrb[0]};
  assign ch_addr  = {a_addr[1], a_addr[0]};
  assign ch_wdata = {a_wdata[1], a_wdata[0]};

  sram_like_arbiter #(
    .N_CH  (N_CH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ch_req      (ch_req),
    .ch_wr       (ch_wr),
    .ch_size     (ch_size),
    .ch_wstrb    (ch_wstrb),
    .ch_addr     (ch_addr),
    .ch_wdata    (ch_wdata),
    .ch_addr_ok  (ch_addr_ok),
    .ch_data_ok  (ch_data_ok),
    .ch_rdata    (ch_rdata),
    .m_req       (m_req),
    .m_wr        (m_wr),
    .m_size      (m_size),
    .m_wstrb     (m_wstrb),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_addr_ok   (m_addr_ok),
    .m_data_ok   (m_data_ok),
    .m_rdata     (m_rdata),
    .outstanding (outstanding),
    .err_unexp   (err_unexp)
  );

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ID queue, last winner, pending-lock channel, sticky error.
  logic [IDW-1:0] mq[$];
  int             lg = N_CH - 1;
  bit             locked = 1'b0;
  logic [IDW-1:0] lock_g = '0;
  bit             merr = 1'b0;

  always @(negedge clk) begin : model
    bit             found;
    bit             exp_mreq;
    logic [IDW-1:0] gi;
    logic [N_CH-1:0] exp_aok;
    logic [N_CH-1:0] exp_dok;
    if (run) begin
      if (!resetn) begin
        mq.delete();
        lg = N_CH - 1;
        locked = 1'b0;
        merr = 1'b0;
        chk("rst_m_req", 64'(m_req), 64'(0));
        chk("rst_addr_ok", 64'(ch_addr_ok), 64'(0));
        chk("rst_data_ok", 64'(ch_data_ok), 64'(0));
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_err", 64'(err_unexp), 64'(0));
      end else begin
        found = 1'b0;
        gi = '0;
        if (locked) begin
          found = 1'b1;
          gi = lock_g;
        end else begin
          for (int k = 1; k <= N_CH; k++) begin
            if (!found && ch_req[IDW'((lg + k) % N_CH)]) begin
              found = 1'b1;
              gi = IDW'((lg + k) % N_CH);
            end
          end
        end
        exp_mreq = found && (mq.size() < DEPTH);
        chk("m_req", 64'(m_req), 64'(exp_mreq));
        if (exp_mreq) begin
          chk("m_addr", 64'(m_addr), 64'(a_addr[gi]));
          chk("m_wdata", 64'(m_wdata), 64'(a_wdata[gi]));
          chk("m_wr", 64'(m_wr), 64'(ch_wr[gi]));
          chk("m_size", 64'(m_size), 64'(a_size[gi]));
          chk("m_wstrb", 64'(m_wstrb), 64'(a_wstrb[gi]));
        end
        exp_aok = '0;
        if (exp_mreq && m_addr_ok) exp_aok[gi] = 1'b1;
        exp_dok = '0;
        if (m_data_ok && mq.size() > 0) exp_dok[mq[0]] = 1'b1;
        chk("ch_addr_ok", 64'(ch_addr_ok), 64'(exp_aok));
        chk("ch_data_ok", 64'(ch_data_ok), 64'(exp_dok));
        if (exp_dok != '0) chk("ch_rdata", 64'(ch_rdata), 64'(m_rdata));
        chk("outstanding", 64'(outstanding), 64'(mq.size()));
        chk("err_unexp", 64'(err_unexp), 64'(merr));
        if (m_data_ok) begin
          if (mq.size() > 0) void'(mq.pop_front());
          else merr = 1'b1;
        end
        if (exp_mreq && m_addr_ok) begin
          mq.push_back(gi);
          lg = int'(gi);
          locked = 1'b0;
        end else if (exp_mreq) begin
          locked = 1'b1;
          lock_g = gi;
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ch_req = '0;
    ch_wr = '0;
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    m_rdata = '0;
    a_addr[0] = 32'h0000_00A0;
    a_addr[1] = 32'h0000_00B1;
    a_wdata[0] = 32'h1111_0000;
    a_wdata[1] = 32'h2222_0001;
    a_size[0] = 2'd2;
    a_size[1] = 2'd1;
    a_wstrb[0] = 4'hF;
    a_wstrb[1] = 4'h3;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    ch_req = '1;
    @(negedge clk);
    chk("lit_rst_m_req", 64'(m_req), 64'(0));
    chk("lit_rst_outstanding", 64'(outstanding), 64'(0));
    next();
    ch_req = '0;
    resetn = 1'b1;
  endtask

  initial begin
    run = 1'b1;
    idle_inputs();

    // Round-robin with both channels requesting, then fill and drain one.
    do_reset();
    ch_req = 2'b11;
    m_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_rr_aok", 64'(ch_addr_ok), (k % 2 == 0) ? 64'h1 : 64'h2);
      chk("lit_rr_addr", 64'(m_addr), (k % 2 == 0) ? 64'hA0 : 64'hB1);
      next();
    end
    m_data_ok = 1'b1;
    m_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("lit_full_outstanding", 64'(outstanding), 64'(4));
    chk("lit_full_m_req", 64'(m_req), 64'(0));
    chk("lit_full_data_ok", 64'(ch_data_ok), 64'h1);
    chk("lit_full_rdata", 64'(ch_rdata), 64'h1234_5678);
    next();
    m_data_ok = 1'b0;
    @(negedge clk);
    chk("lit_after_pop_m_req", 64'(m_req), 64'(1));
    chk("lit_after_pop_outstanding", 64'(outstanding), 64'(3));
    chk("lit_after_pop_aok", 64'(ch_addr_ok), 64'h1);
    next();
    ch_req = '0;
    m_addr_ok = 1'b0;

    // Simultaneous push and pop at count 2.
    do_reset();
    ch_req = 2'b01;
    m_addr_ok = 1'b1;
    next();
    next();
    ch_req = 2'b10;
    m_data_ok = 1'b1;
    m_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("lit_pp_aok", 64'(ch_addr_ok), 64'h2);
    chk("lit_pp_dok", 64'(ch_data_ok), 64'h1);
    chk("lit_pp_cnt_before", 64'(outstanding), 64'(2));
    next();
    ch_req = '0;
    m_rdata = 32'hCAFE_0002;
    @(negedge clk);
    chk("lit_pp_cnt_after", 64'(outstanding), 64'(2));
    chk("lit_pp_dok2", 64'(ch_data_ok), 64'h1);
    next();
    @(negedge clk);
    chk("lit_pp_dok3", 64'(ch_data_ok), 64'h2);
    chk("lit_pp_cnt3", 64'(outstanding), 64'(1));
    next();
    m_data_ok = 1'b0;
    m_addr_ok = 1'b0;

    // Lock holds channel 0 while ch1 waits.
    do_reset();
    ch_req = 2'b01;
    @(negedge clk);
    chk("lit_lock_addr0", 64'(m_addr), 64'hA0);
    next();
    ch_req = 2'b11;
    @(negedge clk);
    chk("lit_lock_addr1", 64'(m_addr), 64'hA0);
    chk("lit_lock_aok1", 64'(ch_addr_ok), 64'h0);
    next();
    @(negedge clk);
    chk("lit_lock_addr2", 64'(m_addr), 64'hA0);
    next();
    m_addr_ok = 1'b1;
    @(negedge clk);
    chk("lit_lock_aok3", 64'(ch_addr_ok), 64'h1);
    next();
    @(negedge clk);
    chk("lit_lock_aok4", 64'(ch_addr_ok), 64'h2);
    chk("lit_lock_addr4", 64'(m_addr), 64'hB1);
    next();
    ch_req = '0;
    m_addr_ok = 1'b0;

    // Unexpected response while empty.
    do_reset();
    m_data_ok = 1'b1;
    @(negedge clk);
    chk("lit_unexp_dok", 64'(ch_data_ok), 64'h0);
    next();
    m_data_ok = 1'b0;
    @(negedge clk);
    chk("lit_unexp_err", 64'(err_unexp), 64'(1));
    repeat (3) next();
    @(negedge clk);
    chk("lit_unexp_err_hold", 64'(err_unexp), 64'(1));
    next();

    // Asynchronous reset with transactions in flight.
    do_reset();
    ch_req = 2'b11;
    m_addr_ok = 1'b1;
    repeat (3) next();
    ch_req = '0;
    m_addr_ok = 1'b0;
    #1;
    chk("lit_arst_before", 64'(outstanding), 64'(3));
    resetn = 1'b0;
    #1;
    chk("lit_arst_cnt", 64'(outstanding), 64'(0));
    chk("lit_arst_m_req", 64'(m_req), 64'(0));
    next();
    resetn = 1'b1;
    ch_req = 2'b11;
    m_addr_ok = 1'b1;
    @(negedge clk);
    chk("lit_arst_grant0", 64'(ch_addr_ok), 64'h1);
    next();
    ch_req = '0;
    m_addr_ok = 1'b0;

    // Randomized traffic with occasional mid-run resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      resetn = ($urandom_range(0, 399) != 0);
      ch_req = N_CH'($urandom_range(0, 3));
      ch_wr = N_CH'($urandom);
      for (int i = 0; i < N_CH; i++) begin
        a_addr[i] = $urandom;
        a_wdata[i] = $urandom;
        a_size[i] = 2'($urandom_range(0, 2));
        a_wstrb[i] = SW'($urandom);
      end
      m_addr_ok = ($urandom_range(0, 9) < 6);
      m_data_ok = ($urandom_range(0, 9) < 4);
      m_rdata = $urandom;
      next();
    end
    resetn = 1'b1;
    idle_inputs();
    next();
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
